// File: rtl/seg_scan_decoder.sv
// Decodes a scanned 4-digit active-low 7-segment bus back into hex nibbles.
// Optional decimal-point capture is enabled by defining SEG_DP_EN.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
`ifdef SEG_DP_EN
    input  logic        dp,
    output logic [3:0]  dp_out,
`endif
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic [3:0]  pattern_error,
    output logic        capture,
    output logic [1:0]  capture_digit
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0] SC = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_e;

    state_e state_q, state_d;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  rec_idx_q, rec_idx_d;
    logic [6:0]  rec_seg_q, rec_seg_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  perr_q, perr_d;
    logic        cap_q, cap_d;
    logic [1:0]  cap_dig_q, cap_dig_d;
    logic [TW-1:0] tmr_q [4];
    logic [TW-1:0] tmr_d [4];
    logic        single;
    logic        same;
    logic        start;
    logic [1:0]  sel_idx;
    logic [4:0]  dec;
`ifdef SEG_DP_EN
    logic        dp_q;
    logic        rec_dp_q, rec_dp_d;
    logic [3:0]  dpo_q, dpo_d;
`endif

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'd0;
        case (s)
            7'h40: r = 5'h10;
            7'h79: r = 5'h11;
            7'h24: r = 5'h12;
            7'h30: r = 5'h13;
            7'h19: r = 5'h14;
            7'h12: r = 5'h15;
            7'h02: r = 5'h16;
            7'h78: r = 5'h17;
            7'h00: r = 5'h18;
            7'h10: r = 5'h19;
            7'h08: r = 5'h1A;
            7'h03: r = 5'h1B;
            7'h27: r = 5'h1C;
            7'h21: r = 5'h1D;
            7'h06: r = 5'h1E;
            7'h0E: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign single = $onehot(~an_q);

    always_comb begin
        sel_idx = 2'd0;
        case (an_q)
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

`ifdef SEG_DP_EN
    assign same = (rec_idx_q == sel_idx) && (rec_seg_q == seg_q)
                  && (rec_dp_q == dp_q);
`else
    assign same = (rec_idx_q == sel_idx) && (rec_seg_q == seg_q);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            rec_idx_q <= 2'd0;
            rec_seg_q <= 7'h7F;
`ifdef SEG_DP_EN
            rec_dp_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rec_idx_q <= rec_idx_d;
            rec_seg_q <= rec_seg_d;
`ifdef SEG_DP_EN
            rec_dp_q  <= rec_dp_d;
`endif
        end
    end

    // Next-state logic; HOLD re-enters the settle path in the same cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rec_idx_d = rec_idx_q;
        rec_seg_d = rec_seg_q;
`ifdef SEG_DP_EN
        rec_dp_d  = rec_dp_q;
`endif
        start     = 1'b0;
        case (state_q)
            IDLE: start = single;
            SETTLE: begin
                if (!single) begin
                    state_d = IDLE;
                end else if (!same) begin
                    start = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == SC) state_d = CAPTURE;
                end
            end
            CAPTURE: state_d = HOLD;
            HOLD: begin
                if (!single) state_d = IDLE;
                else if (!same) start = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            rec_idx_d = sel_idx;
            rec_seg_d = seg_q;
`ifdef SEG_DP_EN
            rec_dp_d  = dp_q;
`endif
            cnt_d     = 8'd1;
            state_d   = (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;
        end
    end

    assign dec = decode(rec_seg_q);

    // Output logic: timeouts first so a same-cycle capture overrides expiry
    always_comb begin
        value_d   = value_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        cap_d     = 1'b0;
        cap_dig_d = cap_dig_q;
`ifdef SEG_DP_EN
        dpo_d     = dpo_q;
`endif
        for (int i = 0; i < 4; i++) begin
            tmr_d[i] = tmr_q[i];
            if (valid_q[i]) begin
                if (tmr_q[i] != TMO) tmr_d[i] = tmr_q[i] + TW'(1);
                if (tmr_d[i] == TMO) valid_d[i] = 1'b0;
            end
        end
        if (state_q == CAPTURE) begin
            cap_d     = 1'b1;
            cap_dig_d = rec_idx_q;
            if (dec[4]) begin
                value_d[{rec_idx_q, 2'b00} +: 4] = dec[3:0];
                valid_d[rec_idx_q] = 1'b1;
                perr_d[rec_idx_q]  = 1'b0;
                tmr_d[rec_idx_q]   = '0;
            end else begin
                valid_d[rec_idx_q] = 1'b0;
                perr_d[rec_idx_q]  = (rec_seg_q != 7'h7F);
            end
`ifdef SEG_DP_EN
            dpo_d[rec_idx_q] = ~rec_dp_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q      <= 4'hF;
            seg_q     <= 7'h7F;
            value_q   <= 16'h0000;
            valid_q   <= 4'h0;
            perr_q    <= 4'h0;
            cap_q     <= 1'b0;
            cap_dig_q <= 2'd0;
            for (int i = 0; i < 4; i++) tmr_q[i] <= '0;
`ifdef SEG_DP_EN
            dp_q      <= 1'b1;
            dpo_q     <= 4'h0;
`endif
        end else begin
            an_q      <= an;
            seg_q     <= seg;
            value_q   <= value_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            cap_q     <= cap_d;
            cap_dig_q <= cap_dig_d;
            for (int i = 0; i < 4; i++) tmr_q[i] <= tmr_d[i];
`ifdef SEG_DP_EN
            dp_q      <= dp;
            dpo_q     <= dpo_d;
`endif
        end
    end

    assign value         = value_q;
    assign digit_valid   = valid_q;
    assign pattern_error = perr_q;
    assign capture       = cap_q;
    assign capture_digit = cap_dig_q;
`ifdef SEG_DP_EN
    assign dp_out        = dpo_q;
`endif

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Monitor and decoder for the multiplexed 4-digit active-low 7-segment bus (anodes plus cathodes), i.e. the receiving end of the hex-to-segment display path.
- Samples the scanned bus, waits for each digit's pattern to settle, and maps the segment pattern back to a 4-bit hex value per digit.
- Used for on-chip self-check of the display path and for loopback of display content into the debug/readback logic.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical samples (same anode, same segments) required before a capture; legal range 1..255.
- TIMEOUT_CYCLES, 1000000, cycles without a capture on a digit before that digit's valid flag drops; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- an  in  4  anode enables, active-low; an[i]=0 selects digit i.
- seg  in  7  cathodes, active-low; seg[0]=a … seg[6]=g.
- value  out  16  decoded nibbles; digit i at value[4i+3:4i].
- digit_valid  out  4  digit i holds a decoded, unexpired value.
- pattern_error  out  4  last capture on digit i was a non-hex, non-blank pattern.
- capture  out  1  one-cycle strobe: a capture occurred this cycle.
- capture_digit  out  2  index of the digit captured; meaningful when capture=1.

Behaviour:
- Input stage: an and seg are registered once. All logic below uses the registered copies (an_q, seg_q).
- Reset: all outputs are 0. State is IDLE; the settle counter and all timeout counters are 0.
- Selection: "single" means exactly one bit of an_q is 0. Zero or several active anodes count as no selection.
- FSM state IDLE:
  - on single → SETTLE; record anode index and seg_q; cnt=1.
- FSM state SETTLE:
  - no single → IDLE.
  - anode index or seg_q differs from recorded → restart SETTLE with the new values; cnt=1.
  - otherwise cnt++.
  - When cnt reaches SETTLE_CYCLES → CAPTURE. With SETTLE_CYCLES=1, go from IDLE directly to CAPTURE on the cycle after the sample.
- FSM state CAPTURE (one cycle):
  - decode the recorded pattern, pulse capture, drive capture_digit.
  - → HOLD.
- FSM state HOLD:
  - stays while anode index and seg_q are unchanged; no further captures.
  - any change → IDLE-equivalent re-entry, evaluated the same cycle: single → SETTLE, else IDLE.
- Decode table (seg_q hex → nibble):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7.
  - 00→8, 10→9, 08→A, 03→b, 27→c, 21→d, 06→E, 0E→F.
- Capture result for digit i:
  - Match: value nibble updated, digit_valid[i]=1, pattern_error[i]=0, timeout counter i cleared.
  - Blank (7F): nibble unchanged, digit_valid[i]=0, pattern_error[i]=0.
  - Any other pattern: nibble unchanged, digit_valid[i]=0, pattern_error[i]=1.
- Outputs update in the same cycle that capture is high, i.e. visible one cycle after CAPTURE is entered. Total latency from the first raw sample of a stable pattern to the capture strobe is SETTLE_CYCLES+1 cycles.
- Timeout:
  - Each digit has a saturating counter that counts every cycle while digit_valid[i]=1.
  - On reaching TIMEOUT_CYCLES: digit_valid[i]←0; nibble and pattern_error[i] are unchanged.
  - A capture on the same cycle as expiry wins: valid stays or becomes 1 per the decode.
- Reset mid-settle or mid-hold: everything returns to reset values on the next edge; no capture strobe is emitted.

Optional Feature:
- SEG_DP_EN defined:
  - adds input dp (1 bit, active-low) and output dp_out (4 bits).
  - dp is registered and included in the stability comparison.
  - On any capture of digit i (hex, blank or error), dp_out[i] ← ~dp_q. Reset value is 0.
- SEG_DP_EN undefined: no dp ports and no dp logic; behaviour otherwise identical.

Test Plan:
- Scan check: rst=1 for 2 cycles then 0. Drive an=1110, seg=7'h30 for 10 cycles.
  - Required: capture=1 exactly once, with capture_digit=0, exactly 5 cycles after the first drive (SETTLE_CYCLES=4).
  - Required: value=16'h0003, digit_valid=0001.
- Full scan: cycle an through 1110/1101/1011/0111 with seg 12, 08, 21, 0E, holding each for 8 cycles.
  - Required: value=16'hFDA5, digit_valid=1111, pattern_error=0000, four capture strobes.
- Glitch and pattern cases:
  - seg changes from 24 to 30 at cnt=3 → no capture for 24; one capture for 3.
  - an=1100 for 20 cycles → no capture.
- Blank and error, starting from digit 2 valid with value 7:
  - Drive seg=7F → digit_valid[2]=0, pattern_error[2]=0, nibble stays 7.
  - Then drive seg=7'h55 → pattern_error[2]=1, nibble still 7.
- Timeout with TIMEOUT_CYCLES=50: capture digit 1, then an=1111.
  - Required: digit_valid[1] falls exactly 50 cycles after the capture cycle; value unchanged.
- Reset mid-settle: assert rst at cnt=2 → no capture pulse, all outputs 0. After release, a fresh 4-cycle settle is required before capture.
